btn_conditioner: RTL and testbench

Multi-channel push-button front end that turns raw, bouncing board keys into clean, clock-synchronous signals. Per channel it synchronises, debounces, and emits one-cycle press and release pulses plus an optional auto-repeat pulse train while the key is held. It sits directly upstream of the 6-bit counter: `btn_pulse[0]` drives its load input and `btn_pulse[1]` drives its enable input, both delivered as single-cycle events.

---
 rtl/btn_conditioner.sv | 142 ++++++++++++++
 tb/tb_btn_conditioner.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: 2-FF synchroniser, debounce, press/release
// edge pulses and optional auto-repeat pulse train, one independent lane per key.
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             reset_btn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_pulse
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    // Raw level that means "released"; XOR with it converts raw to pressed-sense.
    localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_REPEAT
    } rpt_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_ch
            logic            r_sync1;
            logic            r_sync2;
            logic [DB_W-1:0] r_db_cnt;
            logic            r_level;
            logic            r_press;
            logic            r_release;
            logic            w_synced;
            logic            w_accept;
            logic            w_acc_press;
            logic            w_acc_release;

            assign w_synced      = r_sync2 ^ RELEASED_RAW;
            assign w_accept      = (w_synced != r_level) && (r_db_cnt == DB_LAST);
            assign w_acc_press   = w_accept & w_synced;
            assign w_acc_release = w_accept & ~w_synced;

            always_ff @(posedge clk or posedge reset_btn) begin
                if (reset_btn) begin
                    r_sync1   <= RELEASED_RAW;
                    r_sync2   <= RELEASED_RAW;
                    r_db_cnt  <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync1   <= btn_raw[gi];
                    r_sync2   <= r_sync1;
                    r_press   <= w_acc_press;
                    r_release <= w_acc_release;
                    // Any agreeing sample restarts the count, so short glitches vanish.
                    if ((w_synced == r_level) || w_accept) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        r_level <= w_synced;
                    end
                end
            end

            assign btn_level[gi]   = r_level;
            assign btn_press[gi]   = r_press;
            assign btn_release[gi] = r_release;

            if (REPEAT_EN != 0) begin : g_rpt
                rpt_state_t       r_state;
                logic [RPT_W-1:0] r_timer;
                logic             r_pulse;

                // Acts on the same edge that accepts the level change, so the
                // timer phase lines up with the registered press pulse.
                always_ff @(posedge clk or posedge reset_btn) begin
                    if (reset_btn) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= w_acc_press;
                        case (r_state)
                            S_IDLE: begin
                                if (w_acc_press) begin
                                    r_state <= S_DELAY;
                                    r_timer <= '0;
                                end
                            end
                            S_DELAY: begin
                                if (w_acc_release) begin
                                    r_state <= S_IDLE;
                                end else if (r_timer == DELAY_LAST) begin
                                    r_state <= S_REPEAT;
                                    r_timer <= '0;
                                    r_pulse <= 1'b1;
                                end else begin
                                    r_timer <= r_timer + 1'b1;
                                end
                            end
                            S_REPEAT: begin
                                if (w_acc_release) begin
                                    r_state <= S_IDLE;
                                end else if (r_timer == PERIOD_LAST) begin
                                    r_timer <= '0;
                                    r_pulse <= 1'b1;
                                end else begin
                                    r_timer <= r_timer + 1'b1;
                                end
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_timer <= '0;
                            end
                        endcase
                    end
                end

                assign btn_pulse[gi] = r_pulse;
            end else begin : g_no_rpt
                assign btn_pulse[gi] = r_press;
            end
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed key scenarios plus random bouncing, compared
// each cycle against a sample-window / press-age reference model.
module tb_btn_conditioner;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         reset_btn = 1'b1;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_pulse;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(N), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset_btn(reset_btn), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_pulse(btn_pulse)
    );

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last DB synchronised samples all
    // disagree with it; repeat ticks follow from the age of the accepted press.
    logic [N-1:0] m_level, m_press, m_release, m_pulse;
    logic         samp [N][DB+1];
    int           t_edge = 0;
    int           press_edge [N];

    task automatic model_reset();
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_pulse   = '0;
        for (int c = 0; c < N; c++) begin
            press_edge[c] = 0;
            for (int j = 0; j <= DB; j++) samp[c][j] = 1'b0;
        end
    endtask

    task automatic model_step();
        t_edge++;
        for (int c = 0; c < N; c++) begin
            logic all_flip;
            int   age;
            all_flip = 1'b1;
            for (int j = 1; j <= DB; j++) if (samp[c][j] == m_level[c]) all_flip = 1'b0;
            m_press[c]   = 1'b0;
            m_release[c] = 1'b0;
            m_pulse[c]   = 1'b0;
            if (all_flip) begin
                m_level[c] = ~m_level[c];
                if (m_level[c]) begin
                    m_press[c]    = 1'b1;
                    m_pulse[c]    = 1'b1;
                    press_edge[c] = t_edge;
                end else begin
                    m_release[c] = 1'b1;
                end
            end else if (m_level[c]) begin
                age = t_edge - press_edge[c];
                if (age == RD || (age > RD && (age - RD) % RP == 0)) m_pulse[c] = 1'b1;
            end
            for (int j = DB; j > 0; j--) samp[c][j] = samp[c][j-1];
            samp[c][0] = ~btn_raw[c];
        end
    endtask

    always @(posedge clk) begin
        if (reset_btn) model_reset();
        else           model_step();
    end

    always @(negedge clk) begin
        if (chk_en && !reset_btn) begin
            chk("level",   btn_level,   m_level);
            chk("press",   btn_press,   m_press);
            chk("release", btn_release, m_release);
            chk("pulse",   btn_pulse,   m_pulse);
        end
    end

    int cnt_press [N];
    int cnt_rel   [N];
    int cnt_pulse [N];
    int cnt_lvl   [N];

    task automatic clear_cnt();
        for (int c = 0; c < N; c++) begin
            cnt_press[c] = 0; cnt_rel[c] = 0; cnt_pulse[c] = 0; cnt_lvl[c] = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int c = 0; c < N; c++) begin
                cnt_press[c] += int'(btn_press[c]);
                cnt_rel[c]   += int'(btn_release[c]);
                cnt_pulse[c] += int'(btn_pulse[c]);
                cnt_lvl[c]   += int'(btn_level[c]);
            end
        end
    endtask

    // Asynchronous reset pulse asserted mid-cycle, held across one rising edge.
    task automatic reset_pulse(input string tag);
        #1 reset_btn = 1'b1;
        model_reset();
        #1;
        chk({tag, "_level"},   btn_level,   0);
        chk({tag, "_press"},   btn_press,   0);
        chk({tag, "_release"}, btn_release, 0);
        chk({tag, "_pulse"},   btn_pulse,   0);
        @(negedge clk);
        reset_btn = 1'b0;
    endtask

    int hold [N];
    int waited;

    initial begin
        model_reset();
        clear_cnt();
        repeat (3) @(negedge clk);
        chk("rst_level",   btn_level,   0);
        chk("rst_press",   btn_press,   0);
        chk("rst_release", btn_release, 0);
        chk("rst_pulse",   btn_pulse,   0);
        reset_btn = 1'b0;
        chk_en    = 1'b1;
        run(5);

        // Clean press / release on channel 0
        clear_cnt();
        btn_raw[0] = 1'b0;
        run(5);
        chk("clean_lat_before", btn_level[0], 0);
        run(1);
        chk("clean_lat_level", btn_level[0], 1);
        chk("clean_lat_press", btn_press[0], 1);
        run(1);
        chk("clean_press_width", btn_press[0], 0);
        run(13);
        btn_raw[0] = 1'b1;
        run(5);
        chk("clean_rel_before", btn_level[0], 1);
        run(1);
        chk("clean_rel_pulse", btn_release[0], 1);
        run(14);
        chk("clean_press_cnt", cnt_press[0], 1);
        chk("clean_rel_cnt",   cnt_rel[0],   1);
        chk("clean_ch1_quiet", cnt_press[1] + cnt_pulse[1] + cnt_rel[1], 0);

        // Bounce rejection on channel 1
        clear_cnt();
        for (int i = 0; i < 4; i++) begin
            btn_raw[1] = 1'b0; run(2);
            btn_raw[1] = 1'b1; run(2);
        end
        run(10);
        chk("bounce_level", cnt_lvl[1],   0);
        chk("bounce_press", cnt_press[1], 0);
        chk("bounce_pulse", cnt_pulse[1], 0);

        // Bounce then settle on channel 0, then held for auto-repeat
        clear_cnt();
        for (int i = 0; i < 3; i++) begin
            btn_raw[0] = 1'b0; run(3);
            btn_raw[0] = 1'b1; run(2);
        end
        btn_raw[0] = 1'b0;
        run(5);
        chk("settle_before", btn_level[0], 0);
        run(1);
        chk("settle_press", btn_press[0], 1);
        chk("settle_press_cnt", cnt_press[0], 1);
        clear_cnt();
        run(39);
        chk("repeat_ticks", cnt_pulse[0] + 1, 7);
        btn_raw[0] = 1'b1;
        run(20);
        chk("repeat_rel_cnt", cnt_rel[0], 1);

        // Reset at debounce count 2, key kept held
        clear_cnt();
        btn_raw[0] = 1'b0;
        run(4);
        reset_pulse("rst_db");
        run(5);
        chk("rst_db_no_press", cnt_press[0], 0);
        run(1);
        chk("rst_db_repress", btn_press[0], 1);
        run(15);
        reset_pulse("rst_rpt");
        run(6);
        chk("rst_rpt_repress", btn_press[0], 1);
        btn_raw[0] = 1'b1;
        run(15);

        // Simultaneous press on both channels
        btn_raw = '0;
        waited  = 0;
        while (btn_press == '0 && waited < 20) begin
            run(1);
            waited++;
        end
        chk("simul_timeout", (waited < 20), 1);
        chk("simul_press", btn_press, 2'b11);
        run(3);
        chk("simul_level", btn_level, 2'b11);
        btn_raw = '1;
        run(15);

        // Random bouncing with occasional asynchronous resets
        for (int c = 0; c < N; c++) hold[c] = 0;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(0, 1));
                    hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, 30))
                                                          : int'($urandom_range(1, 5));
                end else begin
                    hold[c]--;
                end
            end
            if ($urandom_range(0, 499) == 0) reset_pulse("rand_rst");
            else @(negedge clk);
        end
        btn_raw = '1;
        run(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
